scu_gen2: RTL

Clocked, parametrised successor to the servo control unit. Sits between the host control register and the PWM driver for one motor channel. Takes a target angle and an ATU angle of configurable width and revolution count. Chooses the shortest rotation direction, computes a bang-bang or proportional duty, and generates the PWM waveform internally with glitch-free, period-aligned updates.

---
 rtl/scu_gen2.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/scu_gen2.sv
// Single-channel servo control unit: shortest-path direction, bang-bang/proportional duty, internal PWM.
// Optional duty ramp limiting is enabled by defining SCU_GEN2_RAMP_EN.
module scu_gen2 #(
    parameter int ANGLE_W      = 12,
    parameter int COUNTS_REV   = 1006,
    parameter int PERIOD_W     = 8,
    parameter int KP_SHIFT     = 4,
    parameter int DEADBAND     = 0,
    parameter int RESET_CYCLES = 16,
    parameter int RAMP_STEP    = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_load,
    input  logic [ANGLE_W-1:0]  target_angle,
    input  logic [PERIOD_W-1:0] pwm_period,
    input  logic [1:0]          mode,
    input  logic [1:0]          cmd,
    input  logic [7:0]          kp,
    input  logic [ANGLE_W-1:0]  atu_angle,
    output logic                pwm_out,
    output logic                direction,
    output logic                brake,
    output logic                reset_out,
    output logic [PERIOD_W-1:0] duty,
    output logic [7:0]          status
);

    localparam int AW1 = ANGLE_W + 1;
    localparam int PRW = AW1 + 8;
    localparam int PW1 = PERIOD_W + 1;
    localparam int RCW = $clog2(RESET_CYCLES + 1);
    localparam logic [AW1-1:0]     REV       = AW1'(COUNTS_REV);
    localparam logic [ANGLE_W-1:0] ANGLE_MAX = ANGLE_W'(COUNTS_REV - 1);
`ifdef SCU_GEN2_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_BRAKE = 2'd2,
        ST_RESET = 2'd3
    } state_t;

    function automatic state_t cmd_state(input logic [1:0] c);
        case (c)
            2'd0:    return ST_TRACK;
            2'd1:    return ST_RESET;
            2'd2:    return ST_BRAKE;
            default: return ST_IDLE;
        endcase
    endfunction

    logic [ANGLE_W-1:0]  target_q;
    logic [PERIOD_W-1:0] period_q;
    logic [1:0]          mode_q;
    logic [1:0]          cmd_q;
    logic [7:0]          kp_q;
    logic                clamped_q;
    logic [ANGLE_W-1:0]  angle_q;

    state_t              state_q, state_next;
    logic [RCW-1:0]      rst_cnt_q, rst_cnt_d;
    logic                pending_q, pending_d;

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] duty_q, duty_d;
    logic                dir_q, dir_d;
    logic                pwm_q, brake_q, reset_out_q;
    logic                at_target_q, angle_err_q;

    // NOTE: every register in this block uses the asynchronous active-low reset and non-blocking updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q  <= '0;
            period_q  <= '0;
            mode_q    <= '0;
            cmd_q     <= '0;
            kp_q      <= '0;
            clamped_q <= 1'b0;
        end else if (cfg_load) begin
            if ({1'b0, target_angle} >= REV) begin
                target_q  <= ANGLE_MAX;
                clamped_q <= 1'b1;
            end else begin
                target_q  <= target_angle;
                clamped_q <= 1'b0;
            end
            period_q <= pwm_period;
            mode_q   <= mode;
            cmd_q    <= cmd;
            kp_q     <= kp;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) angle_q <= '0;
        else          angle_q <= atu_angle;
    end

    // Shortest-path error on the circle of COUNTS_REV positions.
    logic [AW1-1:0] diff, cw, ccw, error;
    logic           dir_next, at_target_c, angle_err_c;

    always_comb begin
        diff = {1'b0, target_q} - {1'b0, angle_q};
        if (target_q < angle_q) diff = diff + REV;
        cw          = diff;
        ccw         = (diff == '0) ? '0 : REV - diff;
        dir_next    = (cw <= ccw);
        error       = dir_next ? cw : ccw;
        at_target_c = (error <= AW1'(DEADBAND));
        angle_err_c = ({1'b0, angle_q} >= REV);
    end

    logic [PRW-1:0]      product, scaled;
    logic [PERIOD_W-1:0] duty_target;

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latches).
    always_comb begin
        product = PRW'(error) * PRW'(kp_q);
        scaled  = product >> KP_SHIFT;
        if (scaled == '0) scaled = PRW'(1);
        duty_target = '0;
        if (!at_target_c && !angle_err_c) begin
            case (mode_q)
                2'd0:    duty_target = period_q;
                2'd1:    duty_target = (scaled > PRW'(period_q)) ? period_q : scaled[PERIOD_W-1:0];
                default: duty_target = '0;
            endcase
        end
    end

    // A load during the reset pulse is remembered and applied when the pulse ends.
    always_comb begin
        state_next = state_q;
        rst_cnt_d  = '0;
        pending_d  = pending_q;
        case (state_q)
            ST_RESET: begin
                if (cfg_load) pending_d = 1'b1;
                if (rst_cnt_q == RCW'(RESET_CYCLES - 1)) begin
                    if (cfg_load)       state_next = cmd_state(cmd);
                    else if (pending_q) state_next = cmd_state(cmd_q);
                    else                state_next = ST_IDLE;
                    pending_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            default: begin
                if (cfg_load) state_next = cmd_state(cmd);
            end
        endcase
    end

    logic           wrap;
    logic [PW1-1:0] ramp_sum;

    always_comb begin
        wrap     = ({1'b0, cnt_q} + PW1'(1)) >= {1'b0, period_q};
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        ramp_sum = {1'b0, duty_q} + PW1'(RAMP_STEP);
        duty_d   = duty_q;
        dir_d    = dir_q;
        if (state_next != ST_TRACK) begin
            duty_d = '0;
        end else if (wrap) begin
            dir_d = dir_next;
            // A reversal while driving inserts one zero-duty period; from standstill it applies directly.
            if (dir_next != dir_q && duty_q != '0) begin
                duty_d = '0;
            end else if (RAMP_EN && duty_target > duty_q && ramp_sum < {1'b0, duty_target}) begin
                duty_d = ramp_sum[PERIOD_W-1:0];
            end else begin
                duty_d = duty_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rst_cnt_q   <= '0;
            pending_q   <= 1'b0;
            cnt_q       <= '0;
            duty_q      <= '0;
            dir_q       <= 1'b0;
            pwm_q       <= 1'b0;
            brake_q     <= 1'b0;
            reset_out_q <= 1'b0;
            at_target_q <= 1'b0;
            angle_err_q <= 1'b0;
        end else begin
            state_q     <= state_next;
            rst_cnt_q   <= rst_cnt_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            pwm_q       <= (state_next == ST_TRACK) && (cnt_d < duty_d);
            brake_q     <= (state_next == ST_BRAKE);
            reset_out_q <= (state_next == ST_RESET);
            at_target_q <= at_target_c;
            angle_err_q <= angle_err_c;
        end
    end

    assign pwm_out   = pwm_q;
    assign direction = dir_q;
    assign brake     = brake_q;
    assign reset_out = reset_out_q;
    assign duty      = duty_q;
    assign status    = {3'b000, state_q, angle_err_q, clamped_q, at_target_q};

endmodule
